trng_ctrl: RTL and testbench

TRNG_CTRL -- requirements
Module: trng_ctrl

---
 rtl/trng_pkg.sv | 30 +++
 rtl/trng_vn_debias.sv | 52 +++++
 rtl/trng_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_trng_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trng_pkg
//  Description : Shared types and constants for the TRNG controller slice.
//                Holds the controller FSM state encoding, the default word
//                width / warm-up / divider-width constants and a small
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_COLLECT = 2'd2,
        ST_OUTPUT  = 2'd3
    } trng_state_t;

    localparam int unsigned c_width_default  = 32;
    localparam int unsigned c_warmup_default = 64;
    localparam int unsigned c_div_w_default  = 8;

    // Bits needed for a counter running 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : trng_pkg
`default_nettype wire

// File: rtl/trng_vn_debias.sv
`default_nettype none
// ============================================================================
//  Module      : trng_vn_debias
//  Description : von Neumann pair extractor. Consecutive strobed bits are
//                grouped into (first, second) pairs; an unequal pair emits
//                the first bit, an equal pair emits nothing.
//  Ports       : clk, rst_n    - clock, async active-low reset
//                clear_i       - drop any half-formed pair (pairing restart)
//                strobe_i      - bit_i is a new sample this cycle
//                bit_i         - sampled raw bit
//                emit_o        - a debiased bit is available this cycle
//                emit_bit_o    - the debiased bit (valid with emit_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_vn_debias (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic strobe_i,
    input  logic bit_i,
    output logic emit_o,
    output logic emit_bit_o
);

    logic r_have_first;   // first half of a pair is held in r_first
    logic r_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have_first <= 1'b0;
            r_first      <= 1'b0;
        end else if (clear_i) begin
            r_have_first <= 1'b0;
            r_first      <= 1'b0;
        end else if (strobe_i) begin
            if (!r_have_first) begin
                r_have_first <= 1'b1;
                r_first      <= bit_i;
            end else begin
                // pair complete: always start a fresh pair next strobe
                r_have_first <= 1'b0;
            end
        end
    end

    // Emission is combinational so the consumer can shift on the same edge
    // that completes the pair.
    assign emit_o     = strobe_i && !clear_i && r_have_first && (r_first != bit_i);
    assign emit_bit_o = r_first;

endmodule : trng_vn_debias
`default_nettype wire

// File: rtl/trng_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trng_ctrl
//  Description : Controller for an external ring-oscillator TRNG macro.
//                Enables the macro, waits WARMUP cycles for it to settle,
//                samples its output every (div+1) cycles, optionally applies
//                von Neumann debiasing, and presents WIDTH-bit words on a
//                valid/ready interface.
//  Ports       : clk, rst_n    - clock, async active-low reset
//                enable_i      - level request to run the generator
//                div_i         - sample period minus one (latched on start)
//                debias_i      - 1 = von Neumann, 0 = raw (latched on start)
//                trng_en_o     - enable to the TRNG macro
//                trng_i        - raw bit from the TRNG macro (same clock)
//                data_o        - random word, zero while valid_o is low
//                valid_o       - data_o valid
//                ready_i       - consumer accept
//                busy_o        - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH  = c_width_default,
    parameter int unsigned WARMUP = c_warmup_default,
    parameter int unsigned DIV_W  = c_div_w_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             debias_i,
    output logic             trng_en_o,
    input  logic             trng_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o
);

    localparam int unsigned c_warm_w = clog2_min1(WARMUP);
    localparam int unsigned c_cnt_w  = clog2_min1(WIDTH);

    trng_state_t          r_state;
    trng_state_t          w_state_nxt;

    logic [c_warm_w-1:0]  r_warm_cnt;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]     r_shift;
    logic [DIV_W-1:0]     r_div;
    logic                 r_debias;

    logic                 w_run_collect;
    logic                 w_strobe;
    logic                 w_vn_clear;
    logic                 w_vn_emit;
    logic                 w_vn_bit;
    logic                 w_shift_en;
    logic                 w_shift_bit;
    logic                 w_warm_done;
    logic                 w_word_done;

    // ------------------------------------------------------------------
    // Sample strobe and bit source
    // ------------------------------------------------------------------
    // Collection only advances while still requested; a drop of enable_i
    // in COLLECT aborts on this edge without touching the datapath.
    assign w_run_collect = (r_state == ST_COLLECT) && enable_i;
    assign w_strobe      = w_run_collect && (r_div_cnt == r_div);
    assign w_warm_done   = (r_warm_cnt == c_warm_w'(WARMUP - 1));

    // Holding the extractor clear outside COLLECT restarts pairing on
    // every COLLECT entry (from WARMUP or after a transfer).
    assign w_vn_clear    = !w_run_collect;

    trng_vn_debias u_vn_debias (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (w_vn_clear),
        .strobe_i   (w_strobe),
        .bit_i      (trng_i),
        .emit_o     (w_vn_emit),
        .emit_bit_o (w_vn_bit)
    );

    assign w_shift_en  = r_debias ? w_vn_emit : w_strobe;
    assign w_shift_bit = r_debias ? w_vn_bit  : trng_i;
    assign w_word_done = w_shift_en && (r_bit_cnt == c_cnt_w'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        trng_en_o   = 1'b0;
        valid_o     = 1'b0;
        busy_o      = 1'b0;
        data_o      = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_state_nxt = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                trng_en_o = 1'b1;
                busy_o    = 1'b1;
                if (!enable_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_warm_done) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                trng_en_o = 1'b1;
                busy_o    = 1'b1;
                if (!enable_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_word_done) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                // The shift register is frozen here, so it is the word.
                trng_en_o = 1'b1;
                busy_o    = 1'b1;
                valid_o   = 1'b1;
                data_o    = r_shift;
                if (ready_i) begin
                    w_state_nxt = enable_i ? ST_COLLECT : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: configuration latch, counters, shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_debias   <= 1'b0;
            r_warm_cnt <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            // Configuration is captured only on the start edge.
            if ((r_state == ST_IDLE) && enable_i) begin
                r_div    <= div_i;
                r_debias <= debias_i;
            end

            if ((r_state == ST_WARMUP) && enable_i && !w_warm_done) begin
                r_warm_cnt <= r_warm_cnt + c_warm_w'(1);
            end else begin
                r_warm_cnt <= '0;
            end

            // Counters sit at zero outside COLLECT, so every COLLECT entry
            // starts a clean divider period and an empty word.
            if (w_run_collect) begin
                r_div_cnt <= w_strobe ? '0 : (r_div_cnt + DIV_W'(1));
                if (w_shift_en) begin
                    r_bit_cnt <= w_word_done ? '0 : (r_bit_cnt + c_cnt_w'(1));
                    r_shift   <= {r_shift[WIDTH-2:0], w_shift_bit};
                end
            end else begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

endmodule : trng_ctrl
`default_nettype wire

// File: tb/tb_trng_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trng_ctrl
//  Description : Directed self-checking bench for trng_ctrl (WIDTH=32,
//                WARMUP=64, DIV_W=8). Inputs change 1 time unit after the
//                rising edge; outputs are sampled at that same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_ctrl;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned WARMUP = 64;
    localparam int unsigned DIV_W  = 8;

    logic             clk;
    logic             rst_n;
    logic             enable_i;
    logic [DIV_W-1:0] div_i;
    logic             debias_i;
    logic             trng_en_o;
    logic             trng_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic             busy_o;

    int n_total;
    int n_bad;

    trng_ctrl #(
        .WIDTH  (WIDTH),
        .WARMUP (WARMUP),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable_i),
        .div_i     (div_i),
        .debias_i  (debias_i),
        .trng_en_o (trng_en_o),
        .trng_i    (trng_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge 0: enable sampled in IDLE. Afterwards the div/debias inputs are
    // scrambled; the controller must keep the latched values.
    task automatic start(input logic [DIV_W-1:0] div, input logic deb);
        enable_i = 1'b1;
        div_i    = div;
        debias_i = deb;
        tick();
        div_i    = 8'hA5;
        debias_i = ~deb;
        chk("start_busy", busy_o, 1);
        chk("start_en", trng_en_o, 1);
    endtask

    // Edges 1..WARMUP with random trng_i, which must be ignored.
    task automatic warmup();
        for (int e = 1; e <= WARMUP; e++) begin
            trng_i = 1'($urandom_range(0, 1));
            tick();
        end
        chk("warm_valid", valid_o, 0);
        chk("warm_en", trng_en_o, 1);
    endtask

    // Raw mode: bit k of the word (MSB first) is presented on the strobe
    // cycle; the other div cycles carry its complement so a mistimed
    // strobe corrupts the word.
    task automatic feed_raw(input logic [31:0] w, input int div);
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j <= div; j++) begin
                trng_i = (j == div) ? w[31-k] : ~w[31-k];
                if (k == 31 && j == div) chk("raw_early_valid", valid_o, 0);
                tick();
            end
        end
    endtask

    // Debias mode, div=0: pairs 10,01,00,11 repeating. Each group of 8
    // strobes yields bits 1,0; the 32nd bit lands on strobe 124
    // (group 15, strobe offset 3), the trailing equal pairs are not needed.
    task automatic feed_debias(input int n);
        logic [7:0] seq;
        seq = 8'b1001_0011;
        for (int s = 0; s < n; s++) begin
            trng_i = seq[7 - (s % 8)];
            if (s == n - 1) chk("vn_early_valid", valid_o, 0);
            tick();
        end
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        enable_i = 1'b0;
        div_i    = '0;
        debias_i = 1'b0;
        trng_i   = 1'b0;
        ready_i  = 1'b0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_en", trng_en_o, 0);
        chk("rst_busy", busy_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_en", trng_en_o, 0);
        chk("idle_busy", busy_o, 0);

        // ---------------- raw, div=0, toggling 1,0,... ----------------
        ready_i = 1'b1;
        start(8'd0, 1'b0);
        warmup();
        feed_raw(32'hAAAA_AAAA, 0);           // valid after edge 96
        chk("raw0_valid", valid_o, 1);
        chk("raw0_data", data_o, 32'hAAAA_AAAA);
        enable_i = 1'b0;
        tick();                                // transfer -> IDLE
        chk("raw0_post_valid", valid_o, 0);
        chk("raw0_post_data", data_o, 0);
        chk("raw0_post_busy", busy_o, 0);
        chk("raw0_post_en", trng_en_o, 0);

        // ---------------- debias, div=0 ----------------
        ready_i = 1'b0;
        start(8'd0, 1'b1);
        warmup();
        feed_debias(124);
        chk("vn_valid", valid_o, 1);
        chk("vn_data", data_o, 32'hAAAA_AAAA);
        enable_i = 1'b0;
        ready_i  = 1'b1;
        tick();
        chk("vn_post_busy", busy_o, 0);
        ready_i  = 1'b0;

        // ---------------- raw, stall then back-to-back word ----------------
        start(8'd0, 1'b0);
        warmup();
        feed_raw(32'hC3A5_0F96, 0);
        chk("st_valid", valid_o, 1);
        chk("st_data", data_o, 32'hC3A5_0F96);
        for (int c = 0; c < 20; c++) begin
            trng_i = 1'($urandom_range(0, 1));
            tick();
            chk("stall_valid", valid_o, 1);
            chk("stall_data", data_o, 32'hC3A5_0F96);
            chk("stall_en", trng_en_o, 1);
        end
        ready_i = 1'b1;
        tick();                                // transfer, stay enabled
        ready_i = 1'b0;
        chk("b2b_valid0", valid_o, 0);
        chk("b2b_data0", data_o, 0);
        chk("b2b_busy", busy_o, 1);
        feed_raw(32'h1234_5678, 0);            // exactly 32 edges, no warmup
        chk("b2b_valid", valid_o, 1);
        chk("b2b_data", data_o, 32'h1234_5678);
        enable_i = 1'b0;
        tick();
        chk("b2b_hold_valid", valid_o, 1);     // enable drop must not retract
        ready_i = 1'b1;
        tick();
        chk("b2b_idle_busy", busy_o, 0);
        ready_i = 1'b0;

        // ---------------- raw, div=3 ----------------
        start(8'd3, 1'b0);
        warmup();
        feed_raw(32'h5EC0_7D1B, 3);            // valid after edge 192
        chk("div3_valid", valid_o, 1);
        chk("div3_data", data_o, 32'h5EC0_7D1B);
        enable_i = 1'b0;
        ready_i  = 1'b1;
        tick();
        ready_i  = 1'b0;
        chk("div3_post_busy", busy_o, 0);

        // ---------------- abort in WARMUP and COLLECT ----------------
        start(8'd0, 1'b0);
        for (int e = 0; e < 10; e++) tick();
        enable_i = 1'b0;
        tick();
        chk("abw_busy", busy_o, 0);
        chk("abw_en", trng_en_o, 0);

        start(8'd0, 1'b0);
        warmup();
        for (int k = 0; k < 10; k++) begin
            trng_i = 1'b1;
            tick();
        end
        enable_i = 1'b0;
        tick();
        chk("abc_en", trng_en_o, 0);
        chk("abc_busy", busy_o, 0);
        chk("abc_valid", valid_o, 0);
        for (int e = 0; e < 40; e++) tick();
        chk("abc_late_valid", valid_o, 0);

        // re-enable: full warmup again, then a fresh word
        start(8'd0, 1'b0);
        for (int e = 1; e <= 32; e++) begin
            trng_i = 1'b0;
            tick();
        end
        chk("rew_mid_valid", valid_o, 0);
        for (int e = 33; e <= WARMUP; e++) begin
            trng_i = 1'b1;
            tick();
        end
        chk("rew_end_valid", valid_o, 0);
        feed_raw(32'h0F0F_3C3C, 0);
        chk("rew_valid", valid_o, 1);
        chk("rew_data", data_o, 32'h0F0F_3C3C);

        // ---------------- async reset while in OUTPUT ----------------
        #2;
        rst_n = 1'b0;
        #1;                                     // still before the next edge
        chk("arst_valid", valid_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_en", trng_en_o, 0);
        chk("arst_busy", busy_o, 0);
        enable_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rel_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_trng_ctrl
`default_nettype wire
